// File: rtl/menu_selector_pkg.sv
// Shared menu definitions for the Pong menus: option codes decoded by the game FSM,
// direction-FSM state encodings and the wrapping cursor step.
package pong_menu_pkg;

  localparam logic [1:0] OPT_CONTINUE = 2'd0;
  localparam logic [1:0] OPT_RESTART  = 2'd1;
  localparam logic [1:0] OPT_EXIT     = 2'd2;

  typedef enum logic [1:0] {
    DIR_IDLE   = 2'd0,
    DIR_HOLD   = 2'd1,
    DIR_REPEAT = 2'd2
  } dir_state_e;

  // Up moves toward 0, down toward last_opt; both wrap around.
  function automatic logic [1:0] cursor_step(input logic [1:0] v, input logic up,
                                             input logic [1:0] last_opt);
    if (up) return (v == 2'd0) ? last_opt : v - 2'd1;
    else    return (v == last_opt) ? 2'd0 : v + 2'd1;
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchronizer followed by a stable-level counter: the output takes the
// synchronized level only after it has differed for DEBOUNCE_CYCLES consecutive cycles.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clock,
  input  logic reset,
  input  logic raw_i,
  output logic level_o
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             meta_q, sync_q;
  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Any sample that agrees with the current output restarts the count.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync_q != level_q) begin
      if (cnt_q == CNT_LAST) level_d = sync_q;
      else                   cnt_d   = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      meta_q  <= raw_i;
      sync_q  <= meta_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/menu_selector.sv
// Joystick menu front end: debounced enter level/strobe plus a wrapping cursor driven by
// per-direction IDLE/HOLD/REPEAT FSMs. Define MENU_AUTOREPEAT_EN to build hold-to-repeat.
module menu_selector
  import pong_menu_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int NUM_OPTIONS     = 3,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       menu_active,
  input  logic       joy_button,
  input  logic       joy_up,
  input  logic       joy_down,
  output logic       enter,
  output logic       enter_pulse,
  output logic [1:0] value
);

  if (NUM_OPTIONS < 2 || NUM_OPTIONS > 4 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
    $error("menu_selector: parameter out of range");
  end

  localparam logic [1:0] LAST_OPT = 2'(NUM_OPTIONS - 1);

  logic       btn_db, btn_q;
  logic [1:0] dir_db, dir_q;        // index 0 = up, 1 = down
  logic [1:0] step;
  logic       menu_q;
  logic [1:0] value_q, value_d;
  logic       both_dirs;
  dir_state_e state_q [2];
  dir_state_e state_d [2];

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_button (
    .clock(clock), .reset(reset), .raw_i(joy_button), .level_o(btn_db));
  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
    .clock(clock), .reset(reset), .raw_i(joy_up), .level_o(dir_db[0]));
  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down (
    .clock(clock), .reset(reset), .raw_i(joy_down), .level_o(dir_db[1]));

  assign both_dirs = dir_db[0] & dir_db[1];

`ifdef MENU_AUTOREPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = (RPT_MAX > 2) ? $clog2(RPT_MAX) : 1;
  localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

  logic [RPT_W-1:0] rpt_q [2];
  logic [RPT_W-1:0] rpt_d [2];
`endif

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      state_d[i] = state_q[i];
      step[i]    = 1'b0;
`ifdef MENU_AUTOREPEAT_EN
      rpt_d[i]   = rpt_q[i];
`endif
      // Pressing both directions parks both FSMs until a fresh press.
      if (!menu_active || !dir_db[i] || both_dirs) begin
        state_d[i] = DIR_IDLE;
`ifdef MENU_AUTOREPEAT_EN
        rpt_d[i]   = '0;
`endif
      end else begin
        case (state_q[i])
          DIR_IDLE: begin
            if (!dir_q[i]) begin
              state_d[i] = DIR_HOLD;
              step[i]    = 1'b1;
`ifdef MENU_AUTOREPEAT_EN
              rpt_d[i]   = '0;
`endif
            end
          end
`ifdef MENU_AUTOREPEAT_EN
          DIR_HOLD: begin
            if (rpt_q[i] == DELAY_LAST) begin
              state_d[i] = DIR_REPEAT;
              step[i]    = 1'b1;
              rpt_d[i]   = '0;
            end else begin
              rpt_d[i]   = rpt_q[i] + 1'b1;
            end
          end
          DIR_REPEAT: begin
            if (rpt_q[i] == PERIOD_LAST) begin
              step[i]  = 1'b1;
              rpt_d[i] = '0;
            end else begin
              rpt_d[i] = rpt_q[i] + 1'b1;
            end
          end
`else
          DIR_HOLD:   state_d[i] = DIR_HOLD;
          DIR_REPEAT: state_d[i] = DIR_HOLD;
`endif
          default:    state_d[i] = DIR_IDLE;
        endcase
      end
    end
  end

  // Entering a menu always lands on the first option, even over a same-cycle step.
  always_comb begin
    value_d = value_q;
    if (menu_active && !menu_q) value_d = OPT_CONTINUE;
    else if (step[0])           value_d = cursor_step(value_q, 1'b1, LAST_OPT);
    else if (step[1])           value_d = cursor_step(value_q, 1'b0, LAST_OPT);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      btn_q   <= 1'b0;
      dir_q   <= 2'b00;
      menu_q  <= 1'b0;
      value_q <= OPT_CONTINUE;
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= DIR_IDLE;
`ifdef MENU_AUTOREPEAT_EN
        rpt_q[i]   <= '0;
`endif
      end
    end else begin
      btn_q   <= btn_db;
      dir_q   <= dir_db;
      menu_q  <= menu_active;
      value_q <= value_d;
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= state_d[i];
`ifdef MENU_AUTOREPEAT_EN
        rpt_q[i]   <= rpt_d[i];
`endif
      end
    end
  end

  assign enter       = btn_db;
  assign enter_pulse = btn_db & ~btn_q;
  assign value       = value_q;

endmodule

// File: tb/tb_menu_selector.sv
// Scoreboard bench for menu_selector: expected cursor values are queued as presses are
// driven and popped whenever the cursor output changes.
module tb_menu_selector;
  import pong_menu_pkg::*;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       menu_active = 1'b0;
  logic       joy_button = 1'b0;
  logic       joy_up = 1'b0;
  logic       joy_down = 1'b0;
  logic       enter, enter_pulse;
  logic [1:0] value;

  int         n_checks = 0;
  int         n_errors = 0;
  int         mval = 0;
  int         exp_q [$];
  logic [1:0] last_v = 2'd0;

  always #5 clock = ~clock;

  menu_selector #(
    .DEBOUNCE_CYCLES(4), .NUM_OPTIONS(3), .REPEAT_DELAY(8), .REPEAT_PERIOD(4)
  ) dut (
    .clock(clock), .reset(reset), .menu_active(menu_active), .joy_button(joy_button),
    .joy_up(joy_up), .joy_down(joy_down), .enter(enter), .enter_pulse(enter_pulse),
    .value(value)
  );

  task automatic check_val(input string tag, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic push_step(input bit up);
    if (up) mval = (mval == 0) ? 2 : mval - 1;
    else    mval = (mval == 2) ? 0 : mval + 1;
    exp_q.push_back(mval);
  endtask

  // Raw held 7 cycles -> debounced high for 7 cycles, short of the first repeat.
  task automatic press(input bit up);
    if (up) joy_up = 1'b1;
    else    joy_down = 1'b1;
    tick(7);
    joy_up   = 1'b0;
    joy_down = 1'b0;
    tick(10);
  endtask

  always @(negedge clock) begin
    if (!reset && value !== last_v) begin
      if (exp_q.size() == 0) check_val("unexpected_step", int'(value), int'(last_v));
      else                   check_val("step", int'(value), exp_q.pop_front());
    end
    last_v = value;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rise_at;
    int glitches;

    tick(3);
    check_val("rst_enter", int'(enter), 0);
    check_val("rst_pulse", int'(enter_pulse), 0);
    check_val("rst_value", int'(value), int'(OPT_CONTINUE));
    reset = 1'b0;
    tick(2);

    // Button bounce with the menu inactive: enter must still follow
    glitches = 0;
    for (int i = 0; i < 8; i++) begin
      joy_button = ((i / 2) % 2) == 0;
      tick(1);
      if (enter) glitches++;
    end
    joy_button = 1'b1;
    rise_at = 0;
    for (int i = 1; i <= 10; i++) begin
      tick(1);
      if (i < 6 && enter) glitches++;
      if (enter && rise_at == 0) begin
        rise_at = i;
        check_val("pulse_on_rise", int'(enter_pulse), 1);
      end else if (rise_at != 0 && i == rise_at + 1) begin
        check_val("pulse_one_cycle", int'(enter_pulse), 0);
        check_val("enter_held", int'(enter), 1);
      end
    end
    check_val("bounce_glitch", glitches, 0);
    check_val("enter_latency", rise_at, 6);
    joy_button = 1'b0;
    tick(8);
    check_val("enter_release", int'(enter), 0);

    // Wrap-around in both directions
    menu_active = 1'b1;
    tick(3);
    push_step(1'b1); press(1'b1);
    check_val("wrap_up", int'(value), int'(OPT_EXIT));
    push_step(1'b0); press(1'b0);
    check_val("wrap_down", int'(value), int'(OPT_CONTINUE));
    push_step(1'b0); press(1'b0);
    push_step(1'b0); press(1'b0);
    check_val("down_1_to_2", int'(value), int'(OPT_EXIT));
    push_step(1'b0); press(1'b0);

    // Held down: auto-repeat or a single step
`ifdef MENU_AUTOREPEAT_EN
    for (int k = 0; k < 7; k++) push_step(1'b0);
`else
    push_step(1'b0);
`endif
    joy_down = 1'b1;
    tick(30);
    joy_down = 1'b0;
    tick(15);
    check_val("hold_final", int'(value), int'(OPT_RESTART));

    // Both directions at once
    joy_up = 1'b1;
    joy_down = 1'b1;
    tick(26);
    check_val("both_hold", int'(value), mval);
    joy_up = 1'b0;
    tick(15);
    check_val("both_release_up", int'(value), mval);
    joy_down = 1'b0;
    tick(10);
    push_step(1'b0); press(1'b0);

    // Menu gating, then menu entry forces the first option
    menu_active = 1'b0;
    tick(2);
    press(1'b0);
    check_val("gated_value", int'(value), int'(OPT_EXIT));
    joy_button = 1'b1;
    tick(8);
    check_val("enter_no_menu", int'(enter), 1);
    joy_button = 1'b0;
    tick(8);
    mval = 0;
    exp_q.push_back(mval);
    menu_active = 1'b1;
    tick(1);
    check_val("menu_entry", int'(value), int'(OPT_CONTINUE));
    tick(3);

    // Asynchronous reset in the middle of a held press
    push_step(1'b0);
    joy_button = 1'b1;
    joy_down = 1'b1;
    tick(9);
    check_val("pre_rst_value", int'(value), 1);
    check_val("pre_rst_enter", int'(enter), 1);
    #1 reset = 1'b1;
    #1;
    check_val("async_value", int'(value), 0);
    check_val("async_enter", int'(enter), 0);
    check_val("async_pulse", int'(enter_pulse), 0);
    mval = 0;
    joy_button = 1'b0;
    joy_down = 1'b0;
    tick(3);
    reset = 1'b0;
    tick(20);
    check_val("no_step_after_rst", int'(value), 0);
    push_step(1'b0); press(1'b0);
    tick(5);
    check_val("queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
